// File: rtl/v_logic_pipe.sv
// v_logic_pipe: bitwise AND/OR/XOR-family vector unit with SEW element masking,
// feeding a fixed-depth result pipeline that stalls globally on backpressure.
module v_logic_pipe #(
   parameter int REQ_DATA_WIDTH = 64,
   parameter int REQ_ADDR_WIDTH = 32,
   parameter int OPSEL_WIDTH    = 3,
   parameter int NUM_STAGES     = 6,
   parameter int MASK_ENABLE    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [REQ_ADDR_WIDTH-1:0]     in_addr,
   input  logic [REQ_DATA_WIDTH-1:0]     in_vec0,
   input  logic [REQ_DATA_WIDTH-1:0]     in_vec1,
   input  logic [REQ_DATA_WIDTH-1:0]     in_old,
   input  logic [OPSEL_WIDTH-1:0]        in_opSel,
   input  logic [1:0]                    in_sew,
   input  logic                          in_vm,
   input  logic [REQ_DATA_WIDTH/8-1:0]   in_elem_en,
   input  logic                          in_mask,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [REQ_DATA_WIDTH-1:0]     out_vec,
   output logic [REQ_ADDR_WIDTH-1:0]     out_addr,
   output logic                          out_mask
);
   localparam int NB     = REQ_DATA_WIDTH / 8;
   localparam int BIDX_W = $clog2(NB);

   logic                      stall;
   logic                      accept;
   logic [2:0]                op;
   logic [REQ_DATA_WIDTH-1:0] op_res;
   logic [REQ_DATA_WIDTH-1:0] merged;
   logic [NB-1:0]             byte_en;
   logic                      mask_bit;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;
   assign mask_bit = (MASK_ENABLE != 0) ? in_mask : 1'b0;

   always_comb begin
      op = in_opSel[2:0];
      if (MASK_ENABLE == 0) op[2] = 1'b0;
      op_res = '0;
      case (op)
         3'b000:  op_res = (MASK_ENABLE != 0) ? (in_vec0 & ~in_vec1) : '0;
         3'b001:  op_res = in_vec0 & in_vec1;
         3'b010:  op_res = in_vec0 | in_vec1;
         3'b011:  op_res = in_vec0 ^ in_vec1;
         3'b100:  op_res = in_vec0 | ~in_vec1;
         3'b101:  op_res = ~(in_vec0 & in_vec1);
         3'b110:  op_res = ~(in_vec0 | in_vec1);
         default: op_res = ~(in_vec0 ^ in_vec1);
      endcase
   end

   // Every SEW is a whole number of bytes, so byte b belongs to element b >> sew.
   always_comb begin
      for (int b = 0; b < NB; b++)
         byte_en[b] = in_elem_en[BIDX_W'(b) >> in_sew];
   end

   always_comb begin
      merged = op_res;
      if ((MASK_ENABLE != 0) && !in_mask && !in_vm) begin
         for (int b = 0; b < NB; b++)
            merged[b*8 +: 8] = byte_en[b] ? op_res[b*8 +: 8] : in_old[b*8 +: 8];
      end
   end

   logic                      st_valid [NUM_STAGES];
   logic [REQ_DATA_WIDTH-1:0] st_vec   [NUM_STAGES];
   logic [REQ_ADDR_WIDTH-1:0] st_addr  [NUM_STAGES];
   logic                      st_mask  [NUM_STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            st_valid[s] <= 1'b0;
            st_vec[s]   <= '0;
            st_addr[s]  <= '0;
            st_mask[s]  <= 1'b0;
         end
      end else if (!stall) begin
         st_valid[0] <= accept;
         st_vec[0]   <= accept ? merged : '0;
         st_addr[0]  <= accept ? in_addr : '0;
         st_mask[0]  <= accept ? mask_bit : 1'b0;
         for (int s = 1; s < NUM_STAGES; s++) begin
            st_valid[s] <= st_valid[s-1];
            st_vec[s]   <= st_vec[s-1];
            st_addr[s]  <= st_addr[s-1];
            st_mask[s]  <= st_mask[s-1];
         end
      end
   end

   assign out_valid = st_valid[NUM_STAGES-1];
   assign out_vec   = st_vec[NUM_STAGES-1];
   assign out_addr  = st_addr[NUM_STAGES-1];
   assign out_mask  = st_mask[NUM_STAGES-1];

endmodule

// File: tb/tb_v_logic_pipe.sv
// Bench for v_logic_pipe: directed vectors, backpressure and reset sequences, and
// random traffic scored against a per-bit element model; a second unmasked build.
module tb_v_logic_pipe;
   localparam int W  = 64;
   localparam int AW = 32;
   localparam int NS = 6;

   typedef struct {
      logic [W-1:0]  a, b, old, exp;
      logic [2:0]    op;
      logic [1:0]    sew;
      logic          vm, m;
      logic [7:0]    en;
      logic [AW-1:0] addr;
   } vec_t;

   typedef struct {
      logic [W-1:0]  vec;
      logic [AW-1:0] addr;
      logic          mask;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, out_mask, in_vm, in_mask;
   logic [AW-1:0] in_addr, out_addr;
   logic [W-1:0]  in_vec0, in_vec1, in_old, out_vec;
   logic [2:0]    in_opSel;
   logic [1:0]    in_sew;
   logic [7:0]    in_elem_en;

   logic          valid_b, ready_b, ovalid_b, oready_b, omask_b, vm_b, mask_b;
   logic [AW-1:0] addr_b, oaddr_b;
   logic [W-1:0]  vec0_b, vec1_b, old_b, ovec_b;
   logic [2:0]    opsel_b;
   logic [1:0]    sew_b;
   logic [7:0]    en_b;

   v_logic_pipe #(.REQ_DATA_WIDTH(W), .REQ_ADDR_WIDTH(AW), .OPSEL_WIDTH(3),
                  .NUM_STAGES(NS), .MASK_ENABLE(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1), .in_old(in_old),
      .in_opSel(in_opSel), .in_sew(in_sew), .in_vm(in_vm), .in_elem_en(in_elem_en),
      .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_vec(out_vec), .out_addr(out_addr), .out_mask(out_mask));

   v_logic_pipe #(.REQ_DATA_WIDTH(W), .REQ_ADDR_WIDTH(AW), .OPSEL_WIDTH(3),
                  .NUM_STAGES(1), .MASK_ENABLE(0)) dut_nomask (
      .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(ready_b),
      .in_addr(addr_b), .in_vec0(vec0_b), .in_vec1(vec1_b), .in_old(old_b),
      .in_opSel(opsel_b), .in_sew(sew_b), .in_vm(vm_b), .in_elem_en(en_b),
      .in_mask(mask_b), .out_valid(ovalid_b), .out_ready(oready_b),
      .out_vec(ovec_b), .out_addr(oaddr_b), .out_mask(omask_b));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Reference: decode table, then per-bit merge by element index j / SEW.
   function automatic logic [W-1:0] model_vec(input logic [W-1:0] a, b, old,
         input logic [2:0] op, input logic [1:0] sew, input logic vm, m,
         input logic [7:0] en);
      logic [W-1:0] r;
      int ew;
      case (op)
         3'd0: r = a & ~b;
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         3'd4: r = a | ~b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = ~(a ^ b);
      endcase
      ew = 8 << sew;
      if (!vm && !m)
         for (int j = 0; j < W; j++)
            if (!en[j / ew]) r[j] = old[j];
      return r;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] a, b, old, input logic [2:0] op,
         input logic [1:0] sew, input logic vm, m, input logic [7:0] en,
         input logic [AW-1:0] addr, input logic [W-1:0] exp);
      vec_t v;
      v.a = a; v.b = b; v.old = old; v.op = op; v.sew = sew; v.vm = vm; v.m = m;
      v.en = en; v.addr = addr; v.exp = exp;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      in_vec0 = v.a; in_vec1 = v.b; in_old = v.old; in_opSel = v.op; in_sew = v.sew;
      in_vm = v.vm; in_mask = v.m; in_elem_en = v.en; in_addr = v.addr;
   endtask

   // Scoreboard on the 6-stage masked instance.
   res_t          sb_q[$];
   int            delivered = 0;
   bit            started = 0;
   logic          prev_stall = 1'b0, prev_rst = 1'b1, prev_mask;
   logic [W-1:0]  prev_vec;
   logic [AW-1:0] prev_addr;

   always @(negedge clk) begin
      res_t e;
      if (started) begin
         check("in_ready_vs_stall", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
         if (prev_stall && !prev_rst) begin
            check("hold_vec", out_vec, prev_vec);
            check("hold_addr", {32'd0, out_addr}, {32'd0, prev_addr});
         end
      end
      if (rst) sb_q.delete();
      else if (started) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_output: got out_vec %h addr %h, required no output", out_vec, out_addr);
            end else begin
               e = sb_q.pop_front();
               check("sb_vec", out_vec, e.vec);
               check("sb_addr", {32'd0, out_addr}, {32'd0, e.addr});
               check("sb_mask", {63'd0, out_mask}, {63'd0, e.mask});
               delivered++;
            end
         end
         if (in_valid && in_ready) begin
            e.vec  = model_vec(in_vec0, in_vec1, in_old, in_opSel, in_sew, in_vm, in_mask, in_elem_en);
            e.addr = in_addr;
            e.mask = in_mask;
            sb_q.push_back(e);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_rst   = rst;
      prev_vec   = out_vec;
      prev_addr  = out_addr;
      prev_mask  = out_mask;
   end

   task automatic run_vec(input vec_t v, input bit chk_lat);
      int lat;
      @(posedge clk); #1;
      drive(v); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) begin
         n_checks++; n_fail++;
         $display("FAIL vec_timeout: got no out_valid within 20 cycles, required a result");
      end else begin
         if (chk_lat) check("latency", 64'(lat), 64'(NS - 1));
         check("vec_out", out_vec, v.exp);
         check("vec_addr", {32'd0, out_addr}, {32'd0, v.addr});
         check("vec_mask", {63'd0, out_mask}, {63'd0, v.m});
      end
   endtask

   localparam logic [W-1:0] PA = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [W-1:0] PB = 64'h0FF0_0FF0_0FF0_0FF0;

   vec_t tv[7];
   vec_t ops[8];
   vec_t tb2[5];
   logic [W-1:0] op_exp[8];

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation time limit, required $finish");
      $fatal(1);
   end

   initial begin
      int   sent, base, w;
      bit   acc, new_req;
      vec_t cur;

      tv[0] = mk(64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, '0, 3'b001, 2'd3, 1'b1, 1'b0, 8'h00, 32'h40, 64'h0F00_0F00_0F00_0F00);
      tv[1] = mk(64'h1111_2222_3333_4444, '0, 64'hAAAA_BBBB_CCCC_DDDD, 3'b010, 2'd1, 1'b0, 1'b0, 8'h05, 32'h44, 64'hAAAA_2222_CCCC_4444);
      tv[2] = mk(64'h1111_2222_3333_4444, '0, 64'hAAAA_BBBB_CCCC_DDDD, 3'b010, 2'd1, 1'b0, 1'b1, 8'h05, 32'h48, 64'h1111_2222_3333_4444);
      tv[3] = mk('1, 64'h0123_4567_89AB_CDEF, '0, 3'b001, 2'd0, 1'b0, 1'b0, 8'hF0, 32'h4C, 64'h0123_4567_0000_0000);
      tv[4] = mk(64'h1111_2222_3333_4444, '0, 64'hAAAA_BBBB_CCCC_DDDD, 3'b010, 2'd2, 1'b0, 1'b0, 8'hFD, 32'h50, 64'hAAAA_BBBB_3333_4444);
      tv[5] = mk(64'h1111_2222_3333_4444, '0, 64'hAAAA_BBBB_CCCC_DDDD, 3'b010, 2'd3, 1'b0, 1'b0, 8'hFE, 32'h54, 64'hAAAA_BBBB_CCCC_DDDD);
      tv[6] = mk(64'hF0F0_F0F0_F0F0_F0F0, '1, '0, 3'b011, 2'd3, 1'b0, 1'b0, 8'h01, 32'h58, 64'h0F0F_0F0F_0F0F_0F0F);

      op_exp = '{64'hA005_A005_A005_A005, 64'h05A0_05A0_05A0_05A0, 64'hAFF5_AFF5_AFF5_AFF5,
                 64'hAA55_AA55_AA55_AA55, 64'hF5AF_F5AF_F5AF_F5AF, 64'hFA5F_FA5F_FA5F_FA5F,
                 64'h500A_500A_500A_500A, 64'h55AA_55AA_55AA_55AA};
      for (int k = 0; k < 8; k++)
         ops[k] = mk(PA, PB, '0, 3'(k), 2'd0, 1'b1, 1'b0, 8'h00, 32'(32'h80 + k), op_exp[k]);

      tb2[0] = mk(PA, PB, '0, 3'b100, 2'd0, 1'b1, 1'b0, 8'h00, 32'h10, 64'h0);
      tb2[1] = mk(PA, PB, '0, 3'b111, 2'd0, 1'b1, 1'b1, 8'h00, 32'h11, 64'hAA55_AA55_AA55_AA55);
      tb2[2] = mk(PA, PB, '1, 3'b001, 2'd1, 1'b0, 1'b0, 8'h00, 32'h12, 64'h05A0_05A0_05A0_05A0);
      tb2[3] = mk(PA, PB, '1, 3'b110, 2'd0, 1'b0, 1'b1, 8'h03, 32'h13, 64'hAFF5_AFF5_AFF5_AFF5);
      tb2[4] = mk(PA, PB, '0, 3'b000, 2'd0, 1'b1, 1'b0, 8'h00, 32'h14, 64'h0);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(tv[0]);
      valid_b = 1'b0; oready_b = 1'b1; vec0_b = '0; vec1_b = '0; old_b = '0;
      opsel_b = '0; sew_b = '0; vm_b = 1'b1; mask_b = 1'b0; en_b = '0; addr_b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_vec", out_vec, 64'd0);
      check("rst_out_addr", {32'd0, out_addr}, 64'd0);
      check("rst_out_mask", {63'd0, out_mask}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_b_out_valid", {63'd0, ovalid_b}, 64'd0);
      started = 1;

      for (int i = 0; i < 7; i++) run_vec(tv[i], i == 0);

      // Eight opcodes back-to-back must come out on consecutive cycles.
      @(posedge clk); #1;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               drive(ops[k]); in_valid = 1'b1;
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 30) begin @(negedge clk); w++; end
            for (int k = 0; k < 8; k++) begin
               check("b2b_valid", {63'd0, out_valid}, 64'd1);
               check("b2b_vec", out_vec, op_exp[k]);
               @(negedge clk);
            end
         end
      join

      // Backpressure: out_ready low in cycles 8..12 of a 10-request stream.
      @(posedge clk); #1;
      base = delivered; sent = 0; new_req = 1;
      for (int c = 0; c < 40; c++) begin
         out_ready = !(c >= 8 && c <= 12);
         if (sent < 10) begin
            if (new_req) begin
               cur = mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                        3'(sent), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                        8'($urandom), 32'(32'h100 + sent), '0);
               drive(cur);
            end
            in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clk);
         if (c <= 14) check("bp_in_ready", {63'd0, in_ready}, {63'd0, !(c >= 8 && c <= 12)});
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         new_req = acc;
         if (acc) sent++;
      end
      check("bp_delivered", 64'(delivered - base), 64'd10);
      check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset with four requests in flight.
      out_ready = 1'b1;
      base = delivered;
      for (int k = 0; k < 4; k++) begin
         drive(ops[k]); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_out_vec", out_vec, 64'd0);
      repeat (12) @(negedge clk);
      check("midrst_none_delivered", 64'(delivered - base), 64'd0);

      // Random traffic with random backpressure, then drain.
      @(posedge clk); #1;
      for (int c = 0; c < 400; c++) begin
         cur = mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  3'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  8'($urandom), $urandom, '0);
         drive(cur);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (NS + 4) @(posedge clk);
      @(negedge clk);
      check("rand_sb_empty", 64'(sb_q.size()), 64'd0);

      // Unmasked build, single-stage: result visible the cycle after acceptance.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vec0_b = tb2[i].a; vec1_b = tb2[i].b; old_b = tb2[i].old; opsel_b = tb2[i].op;
         sew_b = tb2[i].sew; vm_b = tb2[i].vm; mask_b = tb2[i].m; en_b = tb2[i].en;
         addr_b = tb2[i].addr; valid_b = 1'b1;
         @(posedge clk); #1;
         valid_b = 1'b0;
         @(negedge clk);
         check("nm_valid", {63'd0, ovalid_b}, 64'd1);
         check("nm_vec", ovec_b, tb2[i].exp);
         check("nm_addr", {32'd0, oaddr_b}, {32'd0, tb2[i].addr});
         check("nm_mask", {63'd0, omask_b}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
